// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: word width, bubble word,
// instruction field positions and default queue depth.
package fetch_queue_pkg;

  localparam int FQ_WORD  = 16;
  localparam int FQ_ENTRY = 2 * FQ_WORD;
  localparam int FQ_DEPTH = 4;

  localparam logic [FQ_WORD-1:0] FQ_NOP_WORD = 16'h2E00;

  localparam int FQ_OPC_MSB = 15;
  localparam int FQ_OPC_LSB = 12;
  localparam int FQ_RD_MSB  = 11;
  localparam int FQ_RD_LSB  = 8;

  function automatic logic [FQ_OPC_MSB-FQ_OPC_LSB:0] opcode_of(input logic [FQ_WORD-1:0] inst);
    return inst[FQ_OPC_MSB:FQ_OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue holding {inst, pc} entries; flush empties it in one cycle.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [FQ_ENTRY-1:0]    din,
  output logic [FQ_ENTRY-1:0]    dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [FQ_ENTRY-1:0] mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;
  logic                do_push_s;
  logic                do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full & ~flush;
  assign do_pop_s  = pop & ~empty & ~flush;

  // Entry storage: contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential reads, tracks the single in-flight
// return, squashes it on redirect and feeds decode from a small queue.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                  DEPTH    = FQ_DEPTH,
  parameter logic [FQ_WORD-1:0]  NOP_WORD = FQ_NOP_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [FQ_WORD-1:0] redirect_pc,
  input  logic               stall,
  input  logic               halt,
  output logic               imem_req,
  output logic [FQ_WORD-1:0] imem_addr,
  input  logic [FQ_WORD-1:0] imem_data,
  output logic [FQ_WORD-1:0] inst_out,
  output logic [FQ_WORD-1:0] pc_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]       count_s;
  logic                full_s;
  logic                empty_s;
  logic [FQ_ENTRY-1:0] head_s;
  logic [FQ_WORD-1:0]  fetch_pc_r;
  logic [FQ_WORD-1:0]  inflight_pc_r;
  logic                inflight_r;
  logic [CW:0]         occupancy_s;
  logic                room_s;
  logic                req_s;
  logic                push_s;
  logic                pop_s;

  // A request is only issued if its return is guaranteed a free slot.
  assign occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
  assign room_s      = (occupancy_s < (CW+1)'(DEPTH));
  assign req_s       = reset & ~halt & ~redirect & room_s;
  assign push_s      = inflight_r & ~redirect & ~full_s;
  assign pop_s       = ~redirect & ~stall & ~empty_s;

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_r;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect),
    .din   ({imem_data, inflight_pc_r}),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Fetch address and in-flight tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r    <= 16'h0000;
      inflight_pc_r <= 16'h0000;
      inflight_r    <= 1'b0;
    end else begin
      inflight_r <= req_s;
      if (redirect) begin
        fetch_pc_r <= redirect_pc;
      end else if (req_s) begin
        inflight_pc_r <= fetch_pc_r;
        fetch_pc_r    <= fetch_pc_r + 16'h0001;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
    end
  end

  // Decode-side output register: bubbles carry NOP_WORD with pc_out held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_out <= NOP_WORD;
      pc_out   <= 16'h0000;
    end else if (redirect || stall) begin
      inst_out <= NOP_WORD;
    end else if (!empty_s) begin
      inst_out <= head_s[FQ_ENTRY-1:FQ_WORD];
      pc_out   <= head_s[FQ_WORD-1:0];
    end else begin
      inst_out <= NOP_WORD;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [15:0] NOP   = 16'h2E00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] inst_out;
  logic [15:0] pc_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  logic        m_inflight;
  logic [15:0] m_inflight_pc;
  logic [15:0] m_fetch_pc;
  logic [15:0] m_inst;
  logic [15:0] m_pc;

  fetch_queue #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .inst_out    (inst_out),
    .pc_out      (pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  // Instruction memory: answers one cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    imem_data <= imem_req ? mem_word(imem_addr) : 16'($urandom);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_inflight    = 1'b0;
    m_inflight_pc = 16'h0000;
    m_fetch_pc    = 16'h0000;
    m_inst        = NOP;
    m_pc          = 16'h0000;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; redirect = 1'b0; stall = 1'b0; halt = 1'b0;
    #1;
    model_reset();
    check_eq("rst_inst", inst_out, NOP);
    check_eq("rst_pc", pc_out, 16'h0000);
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_addr", imem_addr, 16'h0000);
    @(posedge clk);
    #1;
    check_eq("rst_inst_hold", inst_out, NOP);
    check_eq("rst_pc_hold", pc_out, 16'h0000);
  endtask

  task automatic step(input logic rd, input logic [15:0] rpc, input logic st, input logic hl);
    logic        exp_req;
    logic [31:0] head;
    @(negedge clk);
    reset = 1'b1; redirect = rd; redirect_pc = rpc; stall = st; halt = hl;
    #1;
    exp_req = !hl && !rd && ((q.size() + int'(m_inflight)) < DEPTH);
    check_eq("imem_req", imem_req, exp_req);
    check_eq("imem_addr", imem_addr, m_fetch_pc);
    @(posedge clk);
    if (rd) begin
      q.delete();
      m_inst     = NOP;
      m_fetch_pc = rpc;
    end else begin
      if (!st && q.size() > 0) begin
        head   = q.pop_front();
        m_inst = head[31:16];
        m_pc   = head[15:0];
      end else begin
        m_inst = NOP;
      end
      if (m_inflight) q.push_back({mem_word(m_inflight_pc), m_inflight_pc});
      if (exp_req) begin
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc    = m_fetch_pc + 16'h0001;
      end
    end
    m_inflight = exp_req;
    #1;
    check_eq("inst_out", inst_out, m_inst);
    check_eq("pc_out", pc_out, m_pc);
  endtask

  initial begin
    model_reset();
    apply_reset();
    apply_reset();

    // Fill from address 0: first output three edges after release.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      if (i >= 2) begin
        check_eq("seq_inst", inst_out, 16'h1000 + 16'(i - 2));
        check_eq("seq_pc", pc_out, 16'(i - 2));
      end
    end

    // Stall until the queue is full, then three more stalled cycles.
    for (int i = 0; i < 12 && q.size() != DEPTH; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check_eq("stall_nop", inst_out, NOP);
      check_eq("stall_req", imem_req, 1'b0);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Three queued entries plus one in flight, then redirect together with stall.
    for (int i = 0; i < 10 && !(q.size() == 3 && m_inflight); i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h0040, 1'b1, 1'b0);
    check_eq("redir_nop", inst_out, NOP);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      check_eq("redir_squash", inst_out, NOP);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("redir_pc", pc_out, 16'h0040);
    check_eq("redir_inst", inst_out, 16'h1040);

    // Address wrap at FFFF.
    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("wrap_pc_ffff", pc_out, 16'hFFFF);
    check_eq("wrap_inst_ffff", inst_out, 16'h0FFF);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("wrap_pc_0000", pc_out, 16'h0000);
    check_eq("wrap_inst_0000", inst_out, 16'h1000);

    // Halt: queue drains to bubbles, no further requests.
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("halt_drained", inst_out, NOP);
    step(1'b1, 16'h0123, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("halt_redir_pc", pc_out, 16'h0123);

    // Mid-stream reset for one cycle, then restart from address 0.
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      if (i >= 2) check_eq("restart_pc", pc_out, 16'(i - 2));
    end

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 16) == 0, 16'($urandom), ($urandom % 4) == 0, ($urandom % 8) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
